ro_stage: RTL
=============

// Module: ro_stage
// PURPOSE
//  Register Operation (RO) stage; consumes instr/instr_set/pc from the RA->RO latch.
//  Reads two 12-bit operands from an internal 16x12 register file and tracks pending writes in a scoreboard.
//  Stalls upstream on RAW hazards.
//  Presents a registered operand bundle to the execute stage over a valid/ready handshake.
// PARAMETERS
//  NREG    16  register count (addr width = $clog2(NREG), 4 at default)
//  DW      12  data/pc/instr width
//  CNT_W   16  width of saturating stall counter
// PORTS
//  clk           in   1    clock, all state on posedge
//  rst           in   1    synchronous, active-high reset
//  in_valid      in   1    latch holds a live instruction
//  instr_in      in   12   instruction word
//  instr_set_in  in   4    instruction set id
//  pc_in         in   12   pc of instruction
//  stall         out  1    comb; upstream latch enable = ~stall
//  out_valid     out  1    operand bundle valid
//  out_ready     in   1    downstream accepts bundle
//  instr_out     out  12   | instr_set_out out 4 | pc_out out 12
//  opa_out       out  12   regfile[rd] (rd = instr[7:4])
//  opb_out       out  12   regfile[rs] (rs = instr[3:0])
//  wb_en         in   1    writeback strobe
//  wb_addr       in   4    writeback register
//  wb_data       in   12   writeback data
//  flush         in   1    kill in-flight bundle, clear scoreboard
//  stall_cnt     out  16   saturating count of stalled cycles
// BEHAVIOUR
//  - Reset: out_valid=0, instr_out=0, instr_set_out=ISET_BASE, pc_out=0, opa/opb=0; all regs=0; scoreboard=0; stall_cnt=0.
//  - Decode: op=instr[11:8]. op==0 is NOP (no reads, no write).
//    Writes rd iff op in 1..B. op C..F read only.
//  - advance = ~out_valid | out_ready.
//  - hazard = in_valid & op!=0 & (pend[rs] | pend[rd]), after bypass rule below.
//  - issue = in_valid & advance & ~hazard & ~flush. stall = in_valid & ~issue.
//  - On issue: bundle registered; out_valid=1 next cycle; latency 1 cycle from latch to out_*.
//    pend[rd] set if instruction writes.
//  - advance & ~issue: out_valid<=0 (bubble).
//  - ~advance: bundle held stable (all out_* frozen).
//  - wb_en: regfile[wb_addr]<=wb_data; pend[wb_addr]<=0.
//  - Same-cycle issue-set and wb-clear of one register: set wins.
//  - flush: out_valid<=0, pend<=0. The wb write still lands. Issue is suppressed that cycle.
//  - stall_cnt +1 each cycle stall=1; saturates at all-ones, no wrap.
//  - Reset mid-operation discards bundle and scoreboard. No partial state survives.
// CONFIGURATION
//  RO_BYPASS_EN defined: when wb_en & wb_addr==rs/rd, that source is not hazarded and takes wb_data this cycle.
//  RO_BYPASS_EN undefined: no bypass. Pending source stalls until the cycle after writeback; operand is read from the regfile.
// STRUCTURE
//  Shared package/header (iset.vh): ISET_* codes, OP_NOP, opcode field positions, the writes_rd decode function.
//  Sub-module ro_scoreboard: NREG pend bits, set/clear/flush ports, two read ports.
//  Regfile and output register stay in ro_stage.
// TESTING
//  1. rst then idle -> out_valid=0, stall=0, stall_cnt=0, instr_set_out=ISET_BASE.
//  2. Issue op=1 rd=3 pc=0x010, out_ready=1 -> next cycle out_valid=1, pc_out=0x010, pend[3]=1.
//  3. Next instr op=2 rs=3 while pend[3] -> stall=1 and stall_cnt increments.
//     wb_en addr=3 data=0xABC -> bypass: issues same cycle with opb=0xABC. No bypass: issues one cycle later with opb=0xABC.
//  4. out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, stall=1; out_ready=1 -> next bundle one cycle later.
//  5. flush with pend[5]=1 and out_valid=1 -> next cycle out_valid=0, pend all 0. Instr reading r5 issues without stall.
//  6. Force 65540 stall cycles -> stall_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/ro_stage_pkg.sv
// ----------------------------------------------------------------------------
// Module   : ro_stage_pkg
// Brief    : Instruction-set codes, opcode field positions and the decode
//            helper that ro_stage and ro_scoreboard share.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ro_stage_pkg;

  typedef logic [3:0] iset_t;
  typedef logic [3:0] op_t;

  localparam iset_t ISET_BASE = 4'h1;
  localparam iset_t ISET_EXT  = 4'h2;
  localparam iset_t ISET_VEC  = 4'h3;

  localparam op_t OP_NOP     = 4'h0;
  localparam op_t OP_LAST_WR = 4'hB;

  localparam int OP_LSB = 8;
  localparam int OP_W   = 4;
  localparam int RD_LSB = 4;
  localparam int RS_LSB = 0;

  // Opcodes 1..B produce a result in rd; C..F only read their sources.
  function automatic logic writes_rd(input op_t op);
    return (op != OP_NOP) && (op <= OP_LAST_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ro_scoreboard.sv
// ----------------------------------------------------------------------------
// Module   : ro_scoreboard
// Brief    : One pending-write bit per register, with set/clear/flush ports
//            and two combinational read ports.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ro_scoreboard #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_addr,
  input  logic          i_flush,
  input  logic [AW-1:0] i_ra_addr,
  output logic          o_ra_pend,
  input  logic [AW-1:0] i_rb_addr,
  output logic          o_rb_pend
);

  logic [NREG-1:0] r_pend;

  for (genvar i = 0; i < NREG; i++) begin : g_pend
    localparam logic [AW-1:0] c_idx = AW'(i);

    // A new producer issuing in the same cycle as an older writeback to the
    // same register must keep the bit set.
    always_ff @(posedge clk) begin
      if (rst || i_flush) begin
        r_pend[i] <= 1'b0;
      end else if (i_set_en && (i_set_addr == c_idx)) begin
        r_pend[i] <= 1'b1;
      end else if (i_clr_en && (i_clr_addr == c_idx)) begin
        r_pend[i] <= 1'b0;
      end
    end
  end

  assign o_ra_pend = r_pend[i_ra_addr];
  assign o_rb_pend = r_pend[i_rb_addr];

endmodule

`default_nettype wire

// File: rtl/ro_stage.sv
// ----------------------------------------------------------------------------
// Module   : ro_stage
// Brief    : Register-operand stage: regfile read, RAW scoreboard stall and a
//            registered valid/ready operand bundle. Define RO_BYPASS_EN to
//            forward same-cycle writeback data into a pending source.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ro_stage
  import ro_stage_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int DW    = 12,
  parameter int CNT_W = 16,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    instr_in,
  input  logic [3:0]       instr_set_in,
  input  logic [DW-1:0]    pc_in,
  output logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    instr_out,
  output logic [3:0]       instr_set_out,
  output logic [DW-1:0]    pc_out,
  output logic [DW-1:0]    opa_out,
  output logic [DW-1:0]    opb_out,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DW-1:0] r_rf [NREG];

  op_t           w_op;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_rs;
  logic          w_pend_rd;
  logic          w_pend_rs;
  logic          w_byp_rd;
  logic          w_byp_rs;
  logic          w_hazard;
  logic          w_advance;
  logic          w_issue;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;

  assign w_op = instr_in[OP_LSB +: OP_W];
  assign w_rd = instr_in[RD_LSB +: AW];
  assign w_rs = instr_in[RS_LSB +: AW];

`ifdef RO_BYPASS_EN
  assign w_byp_rd = wb_en && (wb_addr == w_rd);
  assign w_byp_rs = wb_en && (wb_addr == w_rs);
`else
  assign w_byp_rd = 1'b0;
  assign w_byp_rs = 1'b0;
`endif

  assign w_hazard  = in_valid && (w_op != OP_NOP) &&
                     ((w_pend_rs && !w_byp_rs) || (w_pend_rd && !w_byp_rd));
  assign w_advance = !out_valid || out_ready;
  assign w_issue   = in_valid && w_advance && !w_hazard && !flush;
  assign stall     = in_valid && !w_issue;

  assign w_opa = w_byp_rd ? wb_data : r_rf[w_rd];
  assign w_opb = w_byp_rs ? wb_data : r_rf[w_rs];

  ro_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_issue && writes_rd(w_op)),
    .i_set_addr (w_rd),
    .i_clr_en   (wb_en),
    .i_clr_addr (wb_addr),
    .i_flush    (flush),
    .i_ra_addr  (w_rd),
    .o_ra_pend  (w_pend_rd),
    .i_rb_addr  (w_rs),
    .o_rb_pend  (w_pend_rs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_en) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Flush drops the bundle but leaves the payload fields untouched; they are
  // qualified by out_valid downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      instr_out     <= '0;
      instr_set_out <= ISET_BASE;
      pc_out        <= '0;
      opa_out       <= '0;
      opb_out       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_issue) begin
      out_valid     <= 1'b1;
      instr_out     <= instr_in;
      instr_set_out <= instr_set_in;
      pc_out        <= pc_in;
      opa_out       <= w_opa;
      opb_out       <= w_opb;
    end else if (w_advance) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire
